// File: rtl/cycle_run_ctrl_pkg.sv
// cycle_run_ctrl_pkg: shared state encoding and default parameter values for the run controller.
//   state_t            controller phases
//   CNT_W_DEF          default cycle counter width
//   RST_CYCLES_DEF     default core reset hold length
//   DEFAULT_CYCLES_DEF default budget when cycle_limit is zero
package cycle_run_ctrl_pkg;
   typedef enum logic [2:0] {IDLE, RESET_HOLD, RUN, STEP_WAIT, DONE} state_t;
   localparam int CNT_W_DEF          = 16;
   localparam int RST_CYCLES_DEF     = 2;
   localparam int DEFAULT_CYCLES_DEF = 16;
endpackage

// File: rtl/cycle_run_ctrl_if.sv
// cycle_run_ctrl_if: control/status bundle between a run supervisor (master) and the controller (slave).
//   start, step_mode, step_req, halt_req, cycle_limit : master -> controller requests
//   core_rst_n, core_en, cycle_cnt                    : controller -> core / supervisor
//   running, done, halted                             : controller status
interface cycle_run_ctrl_if
   import cycle_run_ctrl_pkg::*;
#(parameter int CNT_W = CNT_W_DEF);
   logic             start;
   logic             step_mode;
   logic             step_req;
   logic             halt_req;
   logic [CNT_W-1:0] cycle_limit;
   logic             core_rst_n;
   logic             core_en;
   logic [CNT_W-1:0] cycle_cnt;
   logic             running;
   logic             done;
   logic             halted;
   modport master (output start, step_mode, step_req, halt_req, cycle_limit,
                   input  core_rst_n, core_en, cycle_cnt, running, done, halted);
   modport slave  (input  start, step_mode, step_req, halt_req, cycle_limit,
                   output core_rst_n, core_en, cycle_cnt, running, done, halted);
endinterface

// File: rtl/cycle_run_ctrl.sv
// cycle_run_ctrl: sequences core reset, then gates the core clock enable for a counted
// free-run or single-step run that ends on budget exhaustion or halt.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cycle_run_ctrl_if slave (requests in, core controls and status out)
module cycle_run_ctrl
   import cycle_run_ctrl_pkg::*;
#(
   parameter int CNT_W          = CNT_W_DEF,
   parameter int RST_CYCLES     = RST_CYCLES_DEF,
   parameter int DEFAULT_CYCLES = DEFAULT_CYCLES_DEF
)(
   input logic             clk,
   input logic             rst_n,
   cycle_run_ctrl_if.slave bus
);
   localparam int HOLD_W = $clog2(RST_CYCLES + 1);
   state_t            state;
   logic [CNT_W-1:0]  limit;
   logic [CNT_W-1:0]  cnt;
   logic [HOLD_W-1:0] hold;
   logic              step;
   logic              core_rst_n;
   logic              core_en;
   logic              running;
   logic              done;
   logic              halted;
   logic              last;
   assign bus.core_rst_n = core_rst_n;
   assign bus.core_en    = core_en;
   assign bus.cycle_cnt  = cnt;
   assign bus.running    = running;
   assign bus.done       = done;
   assign bus.halted     = halted;
   // the edge that executes the final budgeted cycle
   assign last = core_en && (cnt + CNT_W'(1) == limit);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         limit      <= '0;
         cnt        <= '0;
         hold       <= '0;
         step       <= 1'b0;
         core_rst_n <= 1'b0;
         core_en    <= 1'b0;
         running    <= 1'b0;
         done       <= 1'b0;
         halted     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: if (bus.start) begin
               limit      <= (bus.cycle_limit == '0) ? CNT_W'(DEFAULT_CYCLES) : bus.cycle_limit;
               step       <= bus.step_mode;
               cnt        <= '0;
               hold       <= '0;
               core_rst_n <= 1'b0;
               running    <= 1'b1;
               done       <= 1'b0;
               halted     <= 1'b0;
               state      <= RESET_HOLD;
            end
            RESET_HOLD: begin
               // a halt during reset hold still releases core reset so DONE looks uniform
               if (bus.halt_req) begin
                  core_rst_n <= 1'b1;
                  running    <= 1'b0;
                  done       <= 1'b1;
                  halted     <= 1'b1;
                  state      <= DONE;
               end else if (hold == HOLD_W'(RST_CYCLES - 1)) begin
                  core_rst_n <= 1'b1;
                  core_en    <= !step;
                  state      <= step ? STEP_WAIT : RUN;
               end else begin
                  hold <= hold + HOLD_W'(1);
               end
            end
            RUN, STEP_WAIT: begin
               if (core_en) cnt <= cnt + CNT_W'(1);
               if (bus.halt_req || last) begin
                  core_en <= 1'b0;
                  running <= 1'b0;
                  done    <= 1'b1;
                  halted  <= bus.halt_req;
                  state   <= DONE;
               end else begin
                  core_en <= (state == RUN) || bus.step_req;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cycle_run_ctrl.sv
// tb_cycle_run_ctrl: directed and randomized checks of cycle_run_ctrl against a reference model.
module tb_cycle_run_ctrl;
   import cycle_run_ctrl_pkg::*;
   localparam int CW = CNT_W_DEF;
   localparam int RC = RST_CYCLES_DEF;
   localparam int DC = DEFAULT_CYCLES_DEF;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cycle_run_ctrl_if #(.CNT_W(CW)) bus();
   cycle_run_ctrl #(.CNT_W(CW), .RST_CYCLES(RC), .DEFAULT_CYCLES(DC)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: reset phase is a countdown of remaining hold cycles,
   // the run phase is a flag; budget exhaustion is plain integer arithmetic.
   int m_hold, m_lim, m_cnt;
   bit m_act, m_stepm, m_en, m_crst, m_done, m_halted;

   task automatic model_reset();
      m_hold = 0; m_lim = 0; m_cnt = 0;
      m_act = 0; m_stepm = 0; m_en = 0; m_crst = 0; m_done = 0; m_halted = 0;
   endtask

   task automatic model_edge();
      if (m_hold == 0 && !m_act) begin
         if (bus.start) begin
            m_lim = (bus.cycle_limit == 0) ? DC : int'(bus.cycle_limit);
            m_stepm = bus.step_mode;
            m_cnt = 0; m_done = 0; m_halted = 0; m_crst = 0;
            m_hold = RC;
         end
      end else if (m_hold > 0) begin
         if (bus.halt_req) begin
            m_hold = 0; m_crst = 1; m_done = 1; m_halted = 1;
         end else begin
            m_hold--;
            if (m_hold == 0) begin
               m_crst = 1; m_en = !m_stepm; m_act = 1;
            end
         end
      end else begin
         if (m_en) m_cnt++;
         if (bus.halt_req || (m_en && m_cnt == m_lim)) begin
            m_en = 0; m_done = 1; m_halted = bus.halt_req; m_act = 0;
         end else begin
            m_en = !m_stepm || bus.step_req;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("core_rst_n", 32'(bus.core_rst_n), 32'(m_crst));
      chk("core_en",    32'(bus.core_en),    32'(m_en));
      chk("cycle_cnt",  32'(bus.cycle_cnt),  32'(m_cnt));
      chk("running",    32'(bus.running),    32'(m_hold > 0 || m_act));
      chk("done",       32'(bus.done),       32'(m_done));
      chk("halted",     32'(bus.halted),     32'(m_halted));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic clear_in();
      bus.start = 0; bus.step_mode = 0; bus.step_req = 0; bus.halt_req = 0; bus.cycle_limit = '0;
   endtask

   task automatic launch(input int lim, input bit sm, output int rst_lo);
      bus.cycle_limit = CW'(lim);
      bus.step_mode = sm;
      bus.start = 1;
      cyc();
      bus.start = 0;
      rst_lo = bus.core_rst_n ? 0 : 1;
   endtask

   task automatic run_to_done(input int budget, inout int en_n, inout int rst_lo);
      for (int i = 0; i < budget && !bus.done; i++) begin
         cyc();
         en_n += bus.core_en ? 1 : 0;
         rst_lo += bus.core_rst_n ? 0 : 1;
      end
   endtask

   initial begin
      int en_n, rst_lo;
      clear_in();
      model_reset();
      #12;
      check_model();
      chk("reset_en", 32'(bus.core_en), 0);
      rst_n = 1;
      repeat (20) cyc();
      chk("idle_running", 32'(bus.running), 0);

      // free run, 16 cycles
      en_n = 0;
      launch(16, 0, rst_lo);
      run_to_done(60, en_n, rst_lo);
      chk("fr_rst_lo", 32'(rst_lo), 32'(RC));
      chk("fr_en_n", 32'(en_n), 16);
      chk("fr_cnt", 32'(bus.cycle_cnt), 16);
      chk("fr_done", 32'(bus.done), 1);
      chk("fr_halted", 32'(bus.halted), 0);
      repeat (3) cyc();
      chk("fr_keep_rst", 32'(bus.core_rst_n), 1);

      // default budget
      en_n = 0;
      launch(0, 0, rst_lo);
      run_to_done(60, en_n, rst_lo);
      chk("def_en_n", 32'(en_n), 16);
      chk("def_cnt", 32'(bus.cycle_cnt), 16);

      // single step, limit 3, 5 requests
      en_n = 0;
      launch(3, 1, rst_lo);
      repeat (RC) cyc();
      for (int p = 0; p < 5; p++) begin
         bus.step_req = 1;
         cyc();
         en_n += bus.core_en ? 1 : 0;
         bus.step_req = 0;
         repeat (2) begin
            cyc();
            en_n += bus.core_en ? 1 : 0;
         end
      end
      chk("st_en_n", 32'(en_n), 3);
      chk("st_cnt", 32'(bus.cycle_cnt), 3);
      chk("st_done", 32'(bus.done), 1);
      chk("st_halted", 32'(bus.halted), 0);

      // halt after 5th enabled cycle
      en_n = 0;
      launch(16, 0, rst_lo);
      for (int i = 0; i < 40 && en_n < 5; i++) begin
         cyc();
         en_n += bus.core_en ? 1 : 0;
      end
      bus.halt_req = 1;
      cyc();
      bus.halt_req = 0;
      chk("ht_cnt", 32'(bus.cycle_cnt), 5);
      chk("ht_done", 32'(bus.done), 1);
      chk("ht_halted", 32'(bus.halted), 1);
      chk("ht_en", 32'(bus.core_en), 0);
      en_n = 0;
      launch(16, 0, rst_lo);
      chk("rs_cnt_clr", 32'(bus.cycle_cnt), 0);
      chk("rs_halt_clr", 32'(bus.halted), 0);
      run_to_done(60, en_n, rst_lo);
      chk("rs_en_n", 32'(en_n), 16);
      chk("rs_cnt", 32'(bus.cycle_cnt), 16);

      // asynchronous reset in the middle of a run
      en_n = 0;
      launch(16, 0, rst_lo);
      for (int i = 0; i < 40 && en_n < 7; i++) begin
         cyc();
         en_n += bus.core_en ? 1 : 0;
      end
      #3 rst_n = 0;
      #1;
      model_reset();
      check_model();
      @(negedge clk);
      rst_n = 1;

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         bus.start = ($urandom_range(0, 9) == 0);
         bus.step_mode = 1'($urandom);
         bus.step_req = ($urandom_range(0, 2) == 0);
         bus.halt_req = ($urandom_range(0, 39) == 0);
         bus.cycle_limit = CW'($urandom_range(0, 12));
         cyc();
      end
      clear_in();
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
